warp_pc_queue: RTL and testbench

Per-warp-slot PC table and in-order pending-issue queue on the fetch side of the SM front end. Drives `next_pc[32]`/`warp_id[32]` and the flow-control flag `update_queue_valid` into the warp fetcher. Accepts its per-issue update stream (`slot`, `valid`, `last`). Retires each issued slot in order when the execute stage resolves it, writing the sequential or branch-target PC back into the slot's table entry.

---
 rtl/warp_pc_queue.sv | 139 +++++++++++++
 tb/tb_warp_pc_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/warp_pc_queue.sv
// Per-slot PC / warp-id table with an in-order queue of issued slots.
// Each resolved head issue writes its sequential or branch-target PC back into the table.
module warp_pc_queue #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PC_STEP = 4,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              initialize,
  input  logic              init_we,
  input  logic [4:0]        init_slot,
  input  logic [31:0]       init_pc,
  input  logic [4:0]        init_warp_id,
  input  logic              upd_valid,
  input  logic [4:0]        upd_slot,
  input  logic              upd_last,
  input  logic              res_valid,
  input  logic [4:0]        res_slot,
  input  logic              res_taken,
  input  logic [31:0]       res_target,
  output logic [31:0][31:0] next_pc,
  output logic [31:0][4:0]  warp_id,
  output logic              update_queue_valid,
  output logic              burst_done,
  output logic [CW-1:0]     count,
  output logic [31:0]       err
);

  logic [31:0][31:0]      pc_q, pc_d;
  logic [31:0][4:0]       wid_q, wid_d;
  logic [DEPTH-1:0][4:0]  fifo_q, fifo_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [31:0][5:0]       pend_q, pend_d;
  logic                   started_q;
  logic                   uqv_q, uqv_d;
  logic                   burst_q, burst_d;
  logic [3:0]             err_q, err_d;
  logic [4:0]             head_s;
  logic                   full_s, empty_s, push_s, pop_s;

  // Next-state computation for queue, pending counters, tables and status flags.
  always_comb begin
    head_s  = fifo_q[rd_ptr_q];
    full_s  = (count_q == CW'(DEPTH));
    empty_s = (count_q == {CW{1'b0}});
    pop_s   = res_valid & ~empty_s & ~initialize;
    // A pop in the same cycle frees the head entry, so a push at full still fits.
    push_s  = upd_valid & ~initialize & (~full_s | pop_s);

    pc_d     = pc_q;
    wid_d    = wid_q;
    fifo_d   = fifo_q;
    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};

    if (push_s) begin
      fifo_d[wr_ptr_q] = upd_slot;
    end else begin
      fifo_d = fifo_q;
    end

    if (pop_s) begin
      pc_d[head_s] = res_taken ? res_target : pc_q[head_s] + 32'(PC_STEP);
    end else begin
      pc_d = pc_q;
    end

    for (int i = 0; i < 32; i++) begin
      pend_d[i] = pend_q[i]
                + {5'd0, push_s & (upd_slot == 5'(i))}
                - {5'd0, pop_s & (head_s == 5'(i))};
    end

    if (initialize) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
      pend_d   = '0;
    end else begin
      count_d  = count_d;
    end

    // Init write is applied last so it overrides a same-slot pop update.
    if (init_we) begin
      pc_d[init_slot]  = init_pc;
      wid_d[init_slot] = init_warp_id;
    end else begin
      wid_d = wid_q;
    end

    uqv_d   = started_q & ~initialize & (count_d <= CW'(DEPTH - 2));
    burst_d = push_s & upd_last;
    err_d   = {init_we & ~initialize & (pend_q[init_slot] != 6'd0),
               pop_s & (res_slot != head_s),
               res_valid & empty_s & ~initialize,
               upd_valid & full_s & ~pop_s & ~initialize};
  end

  // State registers; everything clears asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      wid_q     <= '0;
      fifo_q    <= '0;
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      pend_q    <= '0;
      started_q <= 1'b0;
      uqv_q     <= 1'b0;
      burst_q   <= 1'b0;
      err_q     <= 4'd0;
    end else begin
      pc_q      <= pc_d;
      wid_q     <= wid_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      started_q <= 1'b1;
      uqv_q     <= uqv_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
    end
  end

  assign next_pc            = pc_q;
  assign warp_id            = wid_q;
  assign update_queue_valid = uqv_q;
  assign burst_done         = burst_q;
  assign count              = count_q;
  assign err                = {28'd0, err_q};

endmodule

// File: tb/tb_warp_pc_queue.sv
// Directed bench for warp_pc_queue: a queue of issued slots plus a PC table model
// predict the table contents after each in-order resolution.
module tb_warp_pc_queue;
  logic              clk = 1'b0;
  logic              rst_n;
  logic              initialize, init_we, upd_valid, upd_last, res_valid, res_taken;
  logic [4:0]        init_slot, init_warp_id, upd_slot, res_slot;
  logic [31:0]       init_pc, res_target;
  logic [31:0][31:0] next_pc;
  logic [31:0][4:0]  warp_id;
  logic              update_queue_valid, burst_done;
  logic [4:0]        count;
  logic [31:0]       err;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_pc [32];
  logic [4:0]  sb [$];
  logic [4:0]  h;

  warp_pc_queue #(.DEPTH(16), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .initialize(initialize), .init_we(init_we),
    .init_slot(init_slot), .init_pc(init_pc), .init_warp_id(init_warp_id),
    .upd_valid(upd_valid), .upd_slot(upd_slot), .upd_last(upd_last),
    .res_valid(res_valid), .res_slot(res_slot), .res_taken(res_taken),
    .res_target(res_target), .next_pc(next_pc), .warp_id(warp_id),
    .update_queue_valid(update_queue_valid), .burst_done(burst_done),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of push/resolve stimulus; the model pops before it pushes.
  task automatic cyc(input logic pv, input logic [4:0] ps, input logic pl,
                     input logic rv, input logic [4:0] rs, input logic rt,
                     input logic [31:0] rtg);
    logic [4:0] hd;
    upd_valid = pv; upd_slot = ps; upd_last = pl;
    res_valid = rv; res_slot = rs; res_taken = rt; res_target = rtg;
    if (!initialize) begin
      if (rv && sb.size() > 0) begin
        hd = sb.pop_front();
        m_pc[hd] = rt ? rtg : m_pc[hd] + 32'd4;
      end
      if (pv && sb.size() < 16) sb.push_back(ps);
    end
    tick();
    upd_valid = 1'b0; upd_last = 1'b0; res_valid = 1'b0; res_taken = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; initialize = 1'b0; init_we = 1'b0; init_slot = 5'd0;
    init_pc = 32'd0; init_warp_id = 5'd0; upd_valid = 1'b0; upd_slot = 5'd0;
    upd_last = 1'b0; res_valid = 1'b0; res_slot = 5'd0; res_taken = 1'b0;
    res_target = 32'd0;
    for (int i = 0; i < 32; i++) m_pc[i] = 32'd0;

    #23;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_uqv", 32'(update_queue_valid), 32'd0);
    chk("rst_err", err, 32'd0);
    chk("rst_burst", 32'(burst_done), 32'd0);
    chk("rst_pc3", next_pc[3], 32'd0);

    tick();
    rst_n = 1'b1;
    init_we = 1'b1; init_slot = 5'd3; init_pc = 32'h100; init_warp_id = 5'd7;
    tick();
    init_we = 1'b0; m_pc[3] = 32'h100;
    chk("init_pc3", next_pc[3], 32'h100);
    chk("init_wid3", 32'(warp_id[3]), 32'd7);
    chk("uqv_edge1", 32'(update_queue_valid), 32'd0);
    tick();
    chk("uqv_edge2", 32'(update_queue_valid), 32'd1);

    cyc(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    chk("push_count", 32'(count), 32'd1);
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 32'd0);
    chk("pop_count", 32'(count), 32'd0);
    chk("nt_pc3", next_pc[3], m_pc[3]);
    cyc(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 32'h400);
    chk("tk_pc3", next_pc[3], 32'h400);

    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 5'(8 + (i % 4)), 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_uqv", 32'(update_queue_valid), 32'((i + 1) <= 14));
    end
    cyc(1'b1, 5'd12, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    chk("ovf_err", err, 32'h1);
    chk("ovf_count", 32'(count), 32'd16);
    tick();
    chk("ovf_err_clr", err, 32'h0);
    h = sb[0];
    cyc(1'b1, 5'd13, 1'b0, 1'b1, h, 1'b1, 32'h8800);
    chk("full_pp_count", 32'(count), 32'd16);
    chk("full_pp_err", err, 32'h0);
    chk("full_pp_pc", next_pc[h], 32'h8800);
    for (int i = 0; i < 16; i++) begin
      h = sb[0];
      cyc(1'b0, 5'd0, 1'b0, 1'b1, h, 1'b0, 32'd0);
      chk("drain_pc", next_pc[h], m_pc[h]);
    end
    chk("drain_count", 32'(count), 32'd0);

    cyc(1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 32'hDEAD);
    chk("empty_err", err, 32'h2);
    chk("empty_pc0", next_pc[0], m_pc[0]);
    cyc(1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 32'h2220);
    chk("slot_err", err, 32'h4);
    chk("slot_pc2", next_pc[2], 32'h2220);
    chk("slot_pc5", next_pc[5], m_pc[5]);

    cyc(1'b1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    chk("burst_0", 32'(burst_done), 32'd0);
    cyc(1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    chk("burst_1", 32'(burst_done), 32'd0);
    cyc(1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 32'd0);
    chk("burst_2", 32'(burst_done), 32'd1);
    tick();
    chk("burst_clr", 32'(burst_done), 32'd0);
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b1, 32'hA000);
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 32'hB000);
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b1, 32'hC000);
    chk("abc_pc1", next_pc[1], 32'hC000);
    chk("abc_pc2", next_pc[2], 32'hB000);
    chk("abc_pc1_model", next_pc[1], m_pc[1]);

    for (int i = 0; i < 3; i++) cyc(1'b1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    chk("pend3_count", 32'(count), 32'd3);
    initialize = 1'b1;
    init_we = 1'b1; init_slot = 5'd1; init_pc = 32'h1234; init_warp_id = 5'd9;
    sb.delete();
    cyc(1'b1, 5'd4, 1'b0, 1'b1, 5'd1, 1'b0, 32'd0);
    initialize = 1'b0; init_we = 1'b0; m_pc[1] = 32'h1234;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_err", err, 32'h0);
    chk("flush_pc1", next_pc[1], 32'h1234);
    chk("flush_wid1", 32'(warp_id[1]), 32'd9);
    chk("flush_uqv", 32'(update_queue_valid), 32'd0);
    tick();
    chk("flush_uqv_back", 32'(update_queue_valid), 32'd1);

    cyc(1'b1, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    init_we = 1'b1; init_slot = 5'd6; init_pc = 32'h600; init_warp_id = 5'd2;
    tick();
    init_we = 1'b0; m_pc[6] = 32'h600;
    chk("pend_init_err", err, 32'h8);
    chk("pend_init_pc6", next_pc[6], 32'h600);
    init_we = 1'b1; init_slot = 5'd6; init_pc = 32'h777;
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1, 32'h999);
    init_we = 1'b0; m_pc[6] = 32'h777;
    chk("init_wins_pc6", next_pc[6], 32'h777);
    chk("init_wins_err", err, 32'h8);
    chk("init_wins_count", 32'(count), 32'd0);

    cyc(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    cyc(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    chk("pre_rst_count", 32'(count), 32'd2);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_pc6", next_pc[6], 32'd0);
    chk("async_uqv", 32'(update_queue_valid), 32'd0);
    chk("async_err", err, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
